// File: rtl/fifo_read_ptr_empty_pkg.sv
// Shared dual-clock FIFO helpers: Gray/binary conversion and depth constants.
// Conversions work on a zero-extended 32-bit value, so any pointer width up to 32 uses them unchanged.
package fifo_read_ptr_empty_pkg;

   localparam int PTR_MAX_W    = 32;
   localparam int SIZE_DEFAULT = 4;
   localparam int DEPTH        = 2**(SIZE_DEFAULT-1);

   typedef logic [PTR_MAX_W-1:0] ptr_max_t;

   // Zero bits above the real width leave the low bits of the decode unaffected.
   function automatic ptr_max_t gray2bin(input ptr_max_t g);
      ptr_max_t b;
      b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
      for (int i = PTR_MAX_W-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic ptr_max_t bin2gray(input ptr_max_t b);
      return (b >> 1) ^ b;
   endfunction

   function automatic int depth_of(input int size);
      return 2**(size-1);
   endfunction

endpackage

// File: rtl/fifo_read_ptr_empty_sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into the local clock domain.
module fifo_read_ptr_empty_sync_2ff #(
   parameter int WIDTH = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q1;
   logic [WIDTH-1:0] r_q2;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_q1 <= '0;
         r_q2 <= '0;
      end else begin
         r_q1 <= i_d;
         r_q2 <= r_q1;
      end
   end

   assign o_q = r_q2;

endmodule

// File: rtl/fifo_read_ptr_empty.sv
// Read-side pointer, empty flag, fill level and underflow pulse for the dual-clock FIFO.
module fifo_read_ptr_empty
   import fifo_read_ptr_empty_pkg::*;
#(
   parameter int size = 4
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_inc,
   input  logic [size-1:0] i_wgray,
   output logic [size-1:0] o_rgray,
   output logic [size-2:0] o_raddr,
   output logic            o_empty,
   output logic [size-1:0] o_level,
   output logic            o_underflow
);

   logic [size-1:0] w_wq2;
   logic [size-1:0] w_wbin_s;
   logic            w_rd;
   logic [size-1:0] w_rbnext;
   logic [size-1:0] w_rgnext;

   logic [size-1:0] r_rbin;
   logic [size-1:0] r_rgray;
   logic            r_empty;
   logic [size-1:0] r_level;
   logic            r_underflow;

   fifo_read_ptr_empty_sync_2ff #(.WIDTH(size)) u_sync_wgray (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_d     (i_wgray),
      .o_q     (w_wq2)
   );

   assign w_wbin_s = size'(gray2bin(ptr_max_t'(w_wq2)));
   assign w_rd     = i_inc & ~r_empty;
   assign w_rbnext = r_rbin + {{(size-1){1'b0}}, w_rd};
   assign w_rgnext = size'(bin2gray(ptr_max_t'(w_rbnext)));

   // Flags use the post-read pointer against the current synchronized write pointer.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rbin      <= '0;
         r_rgray     <= '0;
         r_empty     <= 1'b1;
         r_level     <= '0;
         r_underflow <= 1'b0;
      end else begin
         r_rbin      <= w_rbnext;
         r_rgray     <= w_rgnext;
         r_empty     <= (w_rgnext == w_wq2);
         r_level     <= w_wbin_s - w_rbnext;
         r_underflow <= i_inc & r_empty;
      end
   end

   assign o_rgray     = r_rgray;
   assign o_raddr     = r_rbin[size-2:0];
   assign o_empty     = r_empty;
   assign o_level     = r_level;
   assign o_underflow = r_underflow;

endmodule
